// File: rtl/riscv_pkg.sv
// rtl/riscv_pkg.sv - shared RV32 constants, fetch FSM state type and base opcodes
package riscv_pkg;

  localparam int unsigned XLEN = 32;

  localparam logic [XLEN-1:0] NOP_INSN         = 32'h0000_0013;
  localparam logic [XLEN-1:0] RESET_PC_DEFAULT = 32'h0000_0000;

  typedef enum logic [1:0] {
    BOOT  = 2'd0,
    FETCH = 2'd1,
    DROP  = 2'd2
  } fetch_state_e;

  // Major opcodes (insn[6:0]) for the downstream decoder
  localparam logic [6:0] OPC_LOAD     = 7'b000_0011;
  localparam logic [6:0] OPC_MISC_MEM = 7'b000_1111;
  localparam logic [6:0] OPC_OP_IMM   = 7'b001_0011;
  localparam logic [6:0] OPC_AUIPC    = 7'b001_0111;
  localparam logic [6:0] OPC_STORE    = 7'b010_0011;
  localparam logic [6:0] OPC_OP       = 7'b011_0011;
  localparam logic [6:0] OPC_LUI      = 7'b011_0111;
  localparam logic [6:0] OPC_BRANCH   = 7'b110_0011;
  localparam logic [6:0] OPC_JALR     = 7'b110_0111;
  localparam logic [6:0] OPC_JAL      = 7'b110_1111;
  localparam logic [6:0] OPC_SYSTEM   = 7'b111_0011;

  function automatic logic [XLEN-1:0] word_align(input logic [XLEN-1:0] addr);
    return {addr[XLEN-1:2], 2'b00};
  endfunction

endpackage

// File: rtl/ifetch_skid.sv
// rtl/ifetch_skid.sv - one-entry instruction/pc holding slot used while the decoder stalls
module ifetch_skid
  import riscv_pkg::*;
(
  input  logic            clk,
  input  logic            rst,
  input  logic            load,
  input  logic            unload,
  input  logic            clear,
  input  logic [XLEN-1:0] data_in,
  input  logic [XLEN-1:0] pc_in,
  output logic            full,
  output logic [XLEN-1:0] data_out,
  output logic [XLEN-1:0] pc_out
);

  logic            full_q, full_d;
  logic [XLEN-1:0] data_q, data_d;
  logic [XLEN-1:0] pc_q, pc_d;

  always_comb begin
    full_d = full_q;
    data_d = data_q;
    pc_d   = pc_q;
    if (clear) begin
      full_d = 1'b0;
    end else if (load) begin
      full_d = 1'b1;
      data_d = data_in;
      pc_d   = pc_in;
    end else if (unload) begin
      full_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      full_q <= 1'b0;
      data_q <= '0;
      pc_q   <= '0;
    end else begin
      full_q <= full_d;
      data_q <= data_d;
      pc_q   <= pc_d;
    end
  end

  assign full     = full_q;
  assign data_out = data_q;
  assign pc_out   = pc_q;

endmodule

// File: rtl/ifetch.sv
// rtl/ifetch.sv - instruction fetch unit with redirect/drop handling; IFETCH_SKID_EN adds a skid slot
module ifetch #(
  parameter logic [31:0] RESET_PC = riscv_pkg::RESET_PC_DEFAULT,
  parameter logic [31:0] NOP_INSN = riscv_pkg::NOP_INSN
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic [31:0] prog,
  output logic [31:0] pc,
  output logic        valid
);
  import riscv_pkg::*;

  fetch_state_e    state_q, state_d;
  logic [XLEN-1:0] fetch_pc_q, fetch_pc_d;
  logic [XLEN-1:0] drop_addr_q, drop_addr_d;
  logic [XLEN-1:0] prog_q, prog_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic            valid_q, valid_d;

  logic            slot_free;
  logic            accepted;
  logic            skid_full, skid_load, skid_unload, skid_clear;
  logic [XLEN-1:0] skid_data, skid_pc;

  assign slot_free = !valid_q || !stall;
  assign accepted  = imem_req && imem_ack;

`ifdef IFETCH_SKID_EN
  ifetch_skid u_skid (
    .clk      (clk),
    .rst      (rst),
    .load     (skid_load),
    .unload   (skid_unload),
    .clear    (skid_clear),
    .data_in  (imem_rdata),
    .pc_in    (imem_addr),
    .full     (skid_full),
    .data_out (skid_data),
    .pc_out   (skid_pc)
  );
`else
  logic unused_skid_ctrl;
  assign skid_full        = 1'b0;
  assign skid_data        = '0;
  assign skid_pc          = '0;
  assign unused_skid_ctrl = skid_load ^ skid_unload ^ skid_clear;
`endif

  // DROP keeps presenting the abandoned address until memory acks it
  always_comb begin
    imem_req  = 1'b0;
    imem_addr = fetch_pc_q;
    unique case (state_q)
      FETCH: begin
`ifdef IFETCH_SKID_EN
        imem_req = !skid_full;
`else
        imem_req = slot_free;
`endif
      end
      DROP: begin
        imem_req  = 1'b1;
        imem_addr = drop_addr_q;
      end
      default: begin
        imem_req = 1'b0;
      end
    endcase
  end

  always_comb begin
    state_d     = state_q;
    fetch_pc_d  = fetch_pc_q;
    drop_addr_d = drop_addr_q;
    prog_d      = prog_q;
    pc_d        = pc_q;
    valid_d     = valid_q;
    skid_load   = 1'b0;
    skid_unload = 1'b0;
    skid_clear  = 1'b0;

    if (redirect) begin
      fetch_pc_d = word_align(redirect_pc);
      valid_d    = 1'b0;
      prog_d     = NOP_INSN;
      skid_clear = 1'b1;
      unique case (state_q)
        BOOT:  state_d = FETCH;
        FETCH: begin
          if (imem_req && !imem_ack) begin
            state_d     = DROP;
            drop_addr_d = imem_addr;
          end
        end
        DROP:    if (imem_ack) state_d = FETCH;
        default: state_d = BOOT;
      endcase
    end else begin
      unique case (state_q)
        BOOT:    state_d = FETCH;
        FETCH:   if (accepted) fetch_pc_d = fetch_pc_q + 32'd4;
        DROP:    if (imem_ack) state_d = FETCH;
        default: state_d = BOOT;
      endcase

      // A skid entry is always older than any data arriving this cycle
      if (slot_free) begin
        if (skid_full) begin
          prog_d      = skid_data;
          pc_d        = skid_pc;
          valid_d     = 1'b1;
          skid_unload = 1'b1;
        end else if (accepted && state_q == FETCH) begin
          prog_d  = imem_rdata;
          pc_d    = imem_addr;
          valid_d = 1'b1;
        end else begin
          prog_d  = NOP_INSN;
          valid_d = 1'b0;
        end
      end else if (accepted && state_q == FETCH) begin
        skid_load = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= BOOT;
      fetch_pc_q  <= word_align(RESET_PC);
      drop_addr_q <= word_align(RESET_PC);
      prog_q      <= NOP_INSN;
      pc_q        <= RESET_PC;
      valid_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      fetch_pc_q  <= fetch_pc_d;
      drop_addr_q <= drop_addr_d;
      prog_q      <= prog_d;
      pc_q        <= pc_d;
      valid_q     <= valid_d;
    end
  end

  assign prog  = prog_q;
  assign pc    = pc_q;
  assign valid = valid_q;

endmodule

// File: tb/tb_ifetch.sv
// tb/tb_ifetch.sv - self-checking bench for ifetch with a behavioural fetch model
module tb_ifetch;

  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst;
  logic        stall;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic [31:0] prog;
  logic [31:0] pc;
  logic        valid;
  logic        ack_en;

  int n_tests = 0;
  int n_fail  = 0;

  ifetch dut (
    .clk         (clk),
    .rst         (rst),
    .stall       (stall),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_ack    (imem_ack),
    .imem_rdata  (imem_rdata),
    .prog        (prog),
    .pc          (pc),
    .valid       (valid)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] mem(input logic [31:0] a);
    return 32'h0050_0093 ^ {a[15:0], a[15:0]};
  endfunction

  assign imem_ack   = ack_en;
  assign imem_rdata = mem(imem_addr);

  function automatic void chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endfunction

  // Behavioural model: what the fetch unit must show, derived from the fetch rules
  logic        m_boot  = 1'b1;
  logic        m_drop  = 1'b0;
  logic        m_valid = 1'b0;
  logic [31:0] m_fpc   = 32'h0;
  logic [31:0] m_hold  = 32'h0;
  logic [31:0] m_prog  = NOP;
  logic [31:0] m_pc    = 32'h0;
  logic [31:0] cons_pc = 32'h0;

  always @(negedge clk) begin : model
    logic        e_req;
    logic        acc;
    logic        was_drop;
    logic [31:0] e_addr;
    if (rst) begin
      chk("rst_req", 32'(imem_req), 32'd0);
      chk("rst_addr", imem_addr, 32'h0);
      chk("rst_valid", 32'(valid), 32'd0);
      chk("rst_prog", prog, NOP);
      chk("rst_pc", pc, 32'h0);
      m_boot = 1'b1; m_drop = 1'b0; m_valid = 1'b0;
      m_fpc = 32'h0; m_prog = NOP; m_pc = 32'h0; cons_pc = 32'h0;
    end else begin
      e_req  = m_boot ? 1'b0 : (m_drop ? 1'b1 : (!m_valid || !stall));
      e_addr = m_drop ? m_hold : m_fpc;
      chk("m_req", 32'(imem_req), 32'(e_req));
      if (e_req) chk("m_addr", imem_addr, e_addr);
      chk("m_valid", 32'(valid), 32'(m_valid));
      chk("m_prog", prog, m_prog);
      if (m_valid) chk("m_pc", pc, m_pc);
      // In-order stream scoreboard: every consumed instruction is the next sequential one
      if (valid && !stall) begin
        chk("stream_pc", pc, cons_pc);
        chk("stream_prog", prog, mem(cons_pc));
        cons_pc = cons_pc + 32'd4;
      end
      if (redirect) cons_pc = redirect_pc & ~32'h3;

      acc      = e_req && imem_ack;
      was_drop = m_drop;
      if (redirect) begin
        if (!m_boot && !m_drop && e_req && !imem_ack) begin
          m_drop = 1'b1;
          m_hold = e_addr;
        end else if (m_drop && imem_ack) begin
          m_drop = 1'b0;
        end
        m_boot  = 1'b0;
        m_fpc   = redirect_pc & ~32'h3;
        m_valid = 1'b0;
        m_prog  = NOP;
      end else begin
        if (m_boot) m_boot = 1'b0;
        else if (m_drop) begin
          if (imem_ack) m_drop = 1'b0;
        end else if (acc) m_fpc = m_fpc + 32'd4;
        if (!m_valid || !stall) begin
          if (acc && !was_drop) begin
            m_valid = 1'b1; m_prog = mem(e_addr); m_pc = e_addr;
          end else begin
            m_valid = 1'b0; m_prog = NOP;
          end
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  logic [19:0] t_stall = 20'b0000_1100_0111_0001_1100;
  logic [19:0] t_ack   = 20'b1101_1011_1001_1101_1011;
  logic [19:0] t_redir = 20'b0000_1000_0010_0000_0000;

  initial begin
    rst = 1'b1; stall = 1'b0; redirect = 1'b0; redirect_pc = 32'h0; ack_en = 1'b1;
    #2;
    chk("reset_valid", 32'(valid), 32'd0);
    chk("reset_prog", prog, 32'h0000_0013);
    @(posedge clk); #1 rst = 1'b0;
    #1 chk("boot_req", 32'(imem_req), 32'd0);

    step(); chk("r020_req", 32'(imem_req), 32'd1); chk("r020_addr0", imem_addr, 32'h0);
    step(); chk("r020_prog", prog, 32'h0050_0093); chk("r020_pc", pc, 32'h0);
    chk("r020_addr4", imem_addr, 32'h4);
    step(); chk("r020_addr8", imem_addr, 32'h8);
    step(); chk("r021_pc8", pc, 32'h8);
    stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step(); chk("r021_hold_pc", pc, 32'h8); chk("r021_hold_valid", 32'(valid), 32'd1);
    end
    stall = 1'b0;
    step(); chk("r021_next_pc", pc, 32'hC);

    ack_en = 1'b0; redirect = 1'b1; redirect_pc = 32'h103;
    step(); redirect = 1'b0;
    chk("r022_valid", 32'(valid), 32'd0); chk("r022_old_addr", imem_addr, 32'h10);
    step(); chk("r022_hold_addr", imem_addr, 32'h10);
    ack_en = 1'b1;
    step(); chk("r022_valid2", 32'(valid), 32'd0); chk("r022_new_addr", imem_addr, 32'h100);
    step(); chk("r022_pc", pc, 32'h100);

    redirect = 1'b1; redirect_pc = 32'h14;
    step(); chk("r012_addr14", imem_addr, 32'h14);
    redirect_pc = 32'h200;
    step(); redirect = 1'b0;
    chk("r023_valid", 32'(valid), 32'd0); chk("r023_addr", imem_addr, 32'h200);
    step(); chk("r023_pc", pc, 32'h200);

    redirect = 1'b1; redirect_pc = 32'hFFFF_FFFC;
    step(); redirect = 1'b0; chk("r024_addr", imem_addr, 32'hFFFF_FFFC);
    step(); chk("r024_wrap", imem_addr, 32'h0); chk("r024_pc", pc, 32'hFFFF_FFFC);

    redirect = 1'b1; redirect_pc = 32'h40;
    step(); redirect = 1'b0; ack_en = 1'b0;
    #1 chk("r025_req", 32'(imem_req), 32'd1); chk("r025_addr", imem_addr, 32'h40);
    rst = 1'b1;
    #1 chk("r025_rst_req", 32'(imem_req), 32'd0); chk("r025_rst_addr", imem_addr, 32'h0);
    chk("r025_rst_valid", 32'(valid), 32'd0);
    ack_en = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    #1 chk("r015_late_ack", 32'(imem_req), 32'd0);
    step(); chk("r025_first_addr", imem_addr, 32'h0);
    step(); chk("r025_first_pc", pc, 32'h0);

    for (int i = 0; i < 20; i++) begin
      stall       = t_stall[i];
      ack_en      = t_ack[i];
      redirect    = t_redir[i];
      redirect_pc = 32'h300 + 32'(i) * 32'h100 + 32'h2;
      @(posedge clk); #1;
    end
    stall = 1'b0; redirect = 1'b0; ack_en = 1'b1;
    repeat (4) @(posedge clk);
    #2;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
